// File: rtl/rs_scheduler_pkg.sv
// rs_scheduler_pkg: shared scheduler types
// Holds the dispatch/issue FSM state encoding used by rs_scheduler.
package rs_scheduler_pkg;
   typedef enum logic {RUN, FLUSH} sched_state_t;
endpackage

// File: rtl/rs_scheduler_if.sv
// rs_scheduler_if: handshake bundle between the scheduler and IQ/ROB/RS bank/ALU
// Ports: iq_valid/iq_ready (IQ head), rob_full/rob_alloc (ROB), rs_empty/load_word
//        (station fill), exe_req/alu_ready/exe_grant (issue), flush/rs_clear, busy_count.
//        slave = scheduler side, master = surrounding pipeline side.
interface rs_scheduler_if #(parameter int NUM_RS = 4);
   localparam int BW = $clog2(NUM_RS + 1);
   logic              iq_valid;
   logic              iq_ready;
   logic              rob_full;
   logic              rob_alloc;
   logic [NUM_RS-1:0] rs_empty;
   logic [NUM_RS-1:0] load_word;
   logic [NUM_RS-1:0] exe_req;
   logic              alu_ready;
   logic [NUM_RS-1:0] exe_grant;
   logic              flush;
   logic [NUM_RS-1:0] rs_clear;
   logic [BW-1:0]     busy_count;
   modport slave (
      input  iq_valid, rob_full, rs_empty, exe_req, alu_ready, flush,
      output iq_ready, rob_alloc, load_word, exe_grant, rs_clear, busy_count
   );
   modport master (
      output iq_valid, rob_full, rs_empty, exe_req, alu_ready, flush,
      input  iq_ready, rob_alloc, load_word, exe_grant, rs_clear, busy_count
   );
endinterface

// File: rtl/rs_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, search starts at ptr_i and wraps
// Ports: req_i request vector, ptr_i start index, en_i arbitration enable,
//        grant_onehot_o one-hot grant, grant_idx_o granted index, grant_valid_o any grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_onehot_o,
   output logic [IW-1:0]      grant_idx_o,
   output logic               grant_valid_o
);
   logic [IW-1:0] idx;
   always_comb begin
      idx            = '0;
      grant_idx_o    = '0;
      grant_valid_o  = 1'b0;
      // Walk the offsets from farthest to nearest so the nearest hit wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr_i) + k) % NUM_REQ);
         if (en_i && req_i[idx]) begin
            grant_idx_o   = idx;
            grant_valid_o = 1'b1;
         end
      end
      grant_onehot_o = grant_valid_o ? NUM_REQ'(1) << grant_idx_o : '0;
   end
endmodule

// File: rtl/rs_scheduler.sv
// rs_scheduler: dispatches IQ heads to free reservation stations and round-robin issues them to one ALU
// Ports: clk, rst (sync, active-high); sched_if (slave modport of rs_scheduler_if) carries
//        the IQ/ROB dispatch handshake, station load/clear strobes, issue requests/grant,
//        the mispredict flush input and the registered occupancy count.
module rs_scheduler
   import rs_scheduler_pkg::*;
#(
   parameter int NUM_RS       = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   rs_scheduler_if.slave     sched_if
);
   localparam int IW = $clog2(NUM_RS);
   localparam int BW = $clog2(NUM_RS + 1);
   localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

   sched_state_t      state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [BW-1:0]     busy_q, busy_d;
   logic              run, fire, grant_v, over, under;
   logic [IW-1:0]     grant_idx;
   logic [NUM_RS-1:0] grant_oh, pick;

   // Outputs are forced quiet while reset is held, whatever state is registered.
   assign run   = state_q == RUN && !rst;
   assign fire  = run && sched_if.iq_valid && !sched_if.rob_full && |sched_if.rs_empty && !sched_if.flush;
   // Isolate the lowest free station.
   assign pick  = sched_if.rs_empty & (~sched_if.rs_empty + NUM_RS'(1));

   rr_arbiter #(.NUM_REQ(NUM_RS)) u_arb (
      .req_i          (sched_if.exe_req),
      .ptr_i          (rr_q),
      .en_i           (run && sched_if.alu_ready && !sched_if.flush),
      .grant_onehot_o (grant_oh),
      .grant_idx_o    (grant_idx),
      .grant_valid_o  (grant_v)
   );

   assign sched_if.iq_ready   = fire;
   assign sched_if.rob_alloc  = fire;
   assign sched_if.load_word  = fire ? pick : '0;
   assign sched_if.exe_grant  = grant_oh;
   assign sched_if.rs_clear   = {NUM_RS{sched_if.flush && !rst}};
   assign sched_if.busy_count = busy_q;

   assign over  = fire && !grant_v && busy_q == BW'(NUM_RS);
   assign under = grant_v && !fire && busy_q == '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      busy_d  = busy_q;
      if (sched_if.flush) begin
         state_d = FLUSH;
         cnt_d   = CW'(FLUSH_CYCLES - 1);
         rr_d    = '0;
         busy_d  = '0;
      end else if (state_q == FLUSH) begin
         state_d = cnt_q == '0 ? RUN : FLUSH;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end else begin
         rr_d   = !grant_v ? rr_q : grant_idx == IW'(NUM_RS - 1) ? '0 : grant_idx + 1'b1;
         // Dispatch and grant in the same cycle cancel; otherwise step, clamped to 0..NUM_RS.
         busy_d = (fire && !grant_v && !over)  ? busy_q + 1'b1 :
                  (grant_v && !fire && !under) ? busy_q - 1'b1 : busy_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         rr_q    <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         busy_q  <= busy_d;
         assert (!(over || under)) else $error("busy_count would leave 0..NUM_RS");
      end
   end
endmodule

// File: tb/tb_rs_scheduler.sv
// tb_rs_scheduler: directed scoreboard bench for rs_scheduler (NUM_RS=4, FLUSH_CYCLES=2)
module tb_rs_scheduler;
   localparam int N  = 4;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rs_scheduler_if #(.NUM_RS(N)) bus ();
   rs_scheduler #(.NUM_RS(N), .FLUSH_CYCLES(FC)) dut (
      .clk      (clk),
      .rst      (rst),
      .sched_if (bus)
   );

   int vectors = 0;
   int errs    = 0;
   int m_state = 0, m_cnt = 0, m_rr = 0, m_busy = 0;
   int exp_busy_q[$];
   logic [N-1:0] e_lw, e_gr, e_clr, empty;
   logic [N-1:0] last_lw, last_gr, last_clr;
   logic         e_fire, last_rdy;
   int           e_gi;
   logic [N-1:0] t2_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check combinational outputs against the model, then the registered count.
   task automatic step(input string tag, input bit v, input bit rf, input logic [N-1:0] emp,
                       input logic [N-1:0] req, input bit ar, input bit fl, input bit r);
      bit run;
      rst = r; bus.iq_valid = v; bus.rob_full = rf; bus.rs_empty = emp;
      bus.exe_req = req; bus.alu_ready = ar; bus.flush = fl;
      #2;
      run    = !r && m_state == 0;
      e_fire = run && v && !rf && emp != 0 && !fl;
      e_lw   = '0;
      for (int i = N - 1; i >= 0; i--) if (e_fire && emp[i]) e_lw = N'(1) << i;
      e_gi = -1;
      for (int k = N - 1; k >= 0; k--) if (run && ar && !fl && req[(m_rr + k) % N]) e_gi = (m_rr + k) % N;
      e_gr  = e_gi >= 0 ? N'(1) << e_gi : '0;
      e_clr = (!r && fl) ? '1 : '0;
      check({tag, ".iq_ready"},  bus.iq_ready,  e_fire);
      check({tag, ".rob_alloc"}, bus.rob_alloc, e_fire);
      check({tag, ".load_word"}, bus.load_word, e_lw);
      check({tag, ".exe_grant"}, bus.exe_grant, e_gr);
      check({tag, ".rs_clear"},  bus.rs_clear,  e_clr);
      last_rdy = bus.iq_ready; last_lw = bus.load_word; last_gr = bus.exe_grant; last_clr = bus.rs_clear;
      if (r) begin
         m_state = 0; m_cnt = 0; m_rr = 0; m_busy = 0;
      end else if (fl) begin
         m_state = 1; m_cnt = FC - 1; m_rr = 0; m_busy = 0;
      end else if (m_state == 1) begin
         if (m_cnt == 0) m_state = 0; else m_cnt--;
      end else begin
         m_busy = m_busy + int'(e_fire) - int'(e_gi >= 0);
         if (e_gi >= 0) m_rr = (e_gi + 1) % N;
      end
      exp_busy_q.push_back(m_busy);
      @(posedge clk);
      #1;
      if (exp_busy_q.size() == 0) begin
         vectors++; errs++;
         $error("FAIL %s.busy_count: observed %0d expected <scoreboard empty>", tag, bus.busy_count);
      end else check({tag, ".busy_count"}, bus.busy_count, exp_busy_q.pop_front());
   endtask

   initial begin
      bus.iq_valid = 0; bus.rob_full = 0; bus.rs_empty = '0;
      bus.exe_req = '0; bus.alu_ready = 0; bus.flush = 0;
      step("rst0", 0, 0, '0, '0, 0, 0, 1);
      step("rst1", 1, 0, 4'b1111, 4'b1111, 1, 0, 1);
      check("rst.busy", bus.busy_count, 0);
      // Fill all four stations in index order, then the full bank holds the head back.
      empty = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step("t1", 1, 0, empty, '0, 0, 0, 0);
         check("t1.order", last_lw, N'(1) << i);
         empty &= ~last_lw;
      end
      check("t1.busy4", bus.busy_count, 4);
      step("t1_full", 1, 0, empty, '0, 0, 0, 0);
      check("t1_full.ready", last_rdy, 0);
      step("no_alu", 0, 0, '0, 4'b1111, 0, 0, 0);
      // Fairness rotation; the fifth cycle also dispatches so occupancy stays in range.
      for (int i = 0; i < 4; i++) begin
         step("t2", 0, 0, '0, 4'b1111, 1, 0, 0);
         check("t2.seq", last_gr, t2_exp[i]);
      end
      step("t2_wrap", 1, 0, 4'b0001, 4'b1111, 1, 0, 0);
      check("t2.wrap", last_gr, t2_exp[4]);
      check("t2.busy", bus.busy_count, 0);
      // Position the pointer at 2, then pattern 1010.
      step("t3_ld", 1, 0, 4'b1100, '0, 0, 0, 0);
      step("t3_ld", 1, 0, 4'b1000, '0, 0, 0, 0);
      step("t3_ptr", 0, 0, '0, 4'b0010, 1, 0, 0);
      step("t3_g3", 0, 0, '0, 4'b1010, 1, 0, 0);
      check("t3.g3", last_gr, 4'b1000);
      step("t3_g1", 1, 0, 4'b0100, 4'b1010, 1, 0, 0);
      check("t3.g1", last_gr, 4'b0010);
      // ROB full blocks dispatch and leaves the count alone.
      step("t4_ld", 1, 0, 4'b0001, '0, 0, 0, 0);
      step("t4_robfull", 1, 1, 4'b1111, '0, 0, 0, 0);
      check("t4.load", last_lw, 0);
      check("t4.busy", bus.busy_count, 1);
      // Flush with three stations occupied.
      step("t5_ld", 1, 0, 4'b0010, '0, 0, 0, 0);
      step("t5_ld", 1, 0, 4'b0100, '0, 0, 0, 0);
      check("t5.busy3", bus.busy_count, 3);
      step("t5_flush", 1, 0, 4'b1000, 4'b1111, 1, 1, 0);
      check("t5.clear", last_clr, 4'b1111);
      check("t5.busy0", bus.busy_count, 0);
      step("t5_blk1", 1, 0, 4'b1000, 4'b1111, 1, 0, 0);
      step("t5_blk2", 1, 0, 4'b1000, 4'b1111, 1, 0, 0);
      step("t5_resume", 1, 0, 4'b1000, '0, 1, 0, 0);
      check("t5.resume", last_rdy, 1);
      // A second pulse inside FLUSH restarts the count and clears again.
      step("t5b_fl", 0, 0, '0, '0, 0, 1, 0);
      step("t5b_refl", 1, 0, 4'b0001, '0, 0, 1, 0);
      check("t5b.reclear", last_clr, 4'b1111);
      step("t5b_blk1", 1, 0, 4'b0001, '0, 0, 0, 0);
      step("t5b_blk2", 1, 0, 4'b0001, '0, 0, 0, 0);
      step("t5b_resume", 1, 0, 4'b0001, '0, 0, 0, 0);
      // Reset in the middle of FLUSH.
      step("t6_fl", 0, 0, '0, 4'b1111, 1, 1, 0);
      step("t6_rst", 0, 0, '0, 4'b1111, 1, 0, 1);
      check("t6.busy", bus.busy_count, 0);
      step("t6_go", 1, 0, 4'b0001, 4'b1111, 1, 0, 0);
      check("t6.first", last_gr, 4'b0001);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
